// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player input controller.
//   - Control index constants for the per-player control word
//     ([0] right, [1] left, [2] down, [3] up, buttons, start, coin, pause).
//   - ctrl_w(): width of one player's control word for a given button count.
//   - KEYMAP: default PS/2 keymap, [player][control] of {ext, scan code}.
//     The table is laid out for the maximum button count, so start/coin/pause
//     always sit at entries 12/13/14 regardless of NUM_BUTTONS.
package player_input_ctrl_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int MAX_BUTTONS = 8;
  localparam int TBL_W       = MAX_BUTTONS + 7;

  localparam int C_RIGHT = 0;
  localparam int C_LEFT  = 1;
  localparam int C_DOWN  = 2;
  localparam int C_UP    = 3;
  localparam int C_BTN0  = 4;

  // Joystick word position of the start bit; coin and pause follow it.
  localparam int J_START = 8;

  // Entry value meaning "no key assigned"; never matches an event.
  localparam logic [8:0] KEY_NONE = 9'h000;

  function automatic int ctrl_w(input int nb);
    return nb + 7;
  endfunction

  function automatic int c_start(input int nb);
    return C_BTN0 + nb;
  endfunction

  function automatic int c_coin(input int nb);
    return C_BTN0 + nb + 1;
  endfunction

  function automatic int c_pause(input int nb);
    return C_BTN0 + nb + 2;
  endfunction

  // Control index -> keymap table column.
  function automatic int tbl_idx(input int c, input int nb);
    return (c < C_BTN0 + nb) ? c : c + (MAX_BUTTONS - nb);
  endfunction

  // Control index -> bit position in the 32-bit joystick word.
  function automatic int joy_idx(input int c, input int nb);
    return (c < C_BTN0 + nb) ? c : c - (C_BTN0 + nb) + J_START;
  endfunction

  localparam logic [8:0] KEYMAP [MAX_PLAYERS][TBL_W] = '{
    // P1: E0 arrows, ctrl/alt/space/shift, 1, 5, P
    '{9'h174, 9'h16B, 9'h172, 9'h175,
      9'h014, 9'h011, 9'h029, 9'h012, KEY_NONE, KEY_NONE, KEY_NONE, KEY_NONE,
      9'h016, 9'h02E, 9'h04D},
    // P2: G/D/F/R (right/left/down/up), A/S/Q/W, 2, 6, no pause
    '{9'h034, 9'h023, 9'h02B, 9'h02D,
      9'h01C, 9'h01B, 9'h015, 9'h01D, KEY_NONE, KEY_NONE, KEY_NONE, KEY_NONE,
      9'h01E, 9'h036, KEY_NONE},
    '{default: KEY_NONE},
    '{default: KEY_NONE}
  };

endpackage

// File: rtl/player_input_ctrl_coin_stretch.sv
// coin_stretch: stretches a raw coin signal into a pulse of at least
// COIN_PULSE cycles. A rising edge while the counter is idle loads it;
// edges that arrive while it is still counting are ignored.
// Ports:
//   clk_sys   in  system clock
//   RESET     in  asynchronous active-high reset
//   coin_raw  in  raw coin level
//   coin_busy out high while the counter is nonzero (combinational from flop)
module coin_stretch #(
  parameter int COIN_PULSE = 16
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic coin_raw,
  output logic coin_busy
);

  logic [15:0] cnt_q, cnt_d;
  logic        prev_q, prev_d;

  always_comb begin
    cnt_d  = cnt_q;
    prev_d = coin_raw;
    if (cnt_q != 16'd0)
      cnt_d = cnt_q - 16'd1;
    else if (coin_raw && !prev_q)
      cnt_d = 16'(COIN_PULSE);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= 16'd0;
      prev_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  assign coin_busy = (cnt_q != 16'd0);

endmodule

// File: rtl/player_input_ctrl.sv
// player_input_ctrl: merges PS/2 keyboard events and HPS joystick words into
// registered per-player control words, with SOCD cleaning, per-button
// autofire and coin pulse stretching.
// Ports:
//   clk_sys      in   system clock
//   RESET        in   asynchronous active-high reset
//   ps2_key      in   [10] toggle, [9] pressed, [8] E0, [7:0] scan code
//   joystick     in   32 bits per player (dirs, buttons, start 8, coin 9, pause 10)
//   autofire_en  in   one enable per player button
//   ctrl_out     out  per player: dirs, buttons, start, coin, pause (registered)
module player_input_ctrl
  import player_input_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_BUTTONS   = 4,
  parameter int COIN_PULSE    = 16,
  parameter int AUTOFIRE_HALF = 4,
  parameter int SOCD_NEUTRAL  = 1
) (
  input  logic                                 clk_sys,
  input  logic                                 RESET,
  input  logic [10:0]                          ps2_key,
  input  logic [32*NUM_PLAYERS-1:0]            joystick,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   autofire_en,
  output logic [NUM_PLAYERS*(NUM_BUTTONS+7)-1:0] ctrl_out
);

  localparam int CW   = ctrl_w(NUM_BUTTONS);
  localparam int NW   = NUM_PLAYERS * CW;
  localparam int AF_W = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

  logic [NW-1:0]          key_q, key_d;
  logic [NW-1:0]          ctrl_q, ctrl_d;
  logic [NW-1:0]          raw;
  logic                   tog_q, tog_d;
  logic                   prime_q, prime_d;
  logic [AF_W-1:0]        af_cnt_q, af_cnt_d;
  logic                   phase_q, phase_d;
  logic                   evt;
  logic                   af_wrap;
  logic [NUM_PLAYERS-1:0] coin_raw;
  logic [NUM_PLAYERS-1:0] coin_busy;
  logic                   unused_joy;

  // Joystick bits beyond the mapped controls are deliberately ignored.
  assign unused_joy = ^joystick;

  // Key events: the first edge after reset only primes the toggle copy.
  always_comb begin
    evt     = prime_q && (ps2_key[10] != tog_q);
    tog_d   = ps2_key[10];
    prime_d = 1'b1;
    key_d   = key_q;
    if (evt) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        for (int c = 0; c < CW; c++) begin
          if (KEYMAP[p][tbl_idx(c, NUM_BUTTONS)] != KEY_NONE &&
              KEYMAP[p][tbl_idx(c, NUM_BUTTONS)] == ps2_key[8:0])
            key_d[p*CW + c] = ps2_key[9];
        end
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int c = 0; c < CW; c++)
        raw[p*CW + c] = key_q[p*CW + c] | joystick[p*32 + joy_idx(c, NUM_BUTTONS)];
    end
  end

  // Shared autofire timebase; phase starts high so held buttons fire at once.
  always_comb begin
    af_wrap  = (af_cnt_q == AF_W'(AUTOFIRE_HALF - 1));
    af_cnt_d = af_wrap ? '0 : af_cnt_q + 1'b1;
    phase_d  = af_wrap ? ~phase_q : phase_q;
  end

  always_comb begin
    ctrl_d   = '0;
    coin_raw = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      ctrl_d[p*CW + C_RIGHT] = raw[p*CW + C_RIGHT];
      ctrl_d[p*CW + C_LEFT]  = raw[p*CW + C_LEFT];
      ctrl_d[p*CW + C_DOWN]  = raw[p*CW + C_DOWN];
      ctrl_d[p*CW + C_UP]    = raw[p*CW + C_UP];
      if (SOCD_NEUTRAL != 0) begin
        if (raw[p*CW + C_RIGHT] && raw[p*CW + C_LEFT]) begin
          ctrl_d[p*CW + C_RIGHT] = 1'b0;
          ctrl_d[p*CW + C_LEFT]  = 1'b0;
        end
        if (raw[p*CW + C_UP] && raw[p*CW + C_DOWN]) begin
          ctrl_d[p*CW + C_UP]   = 1'b0;
          ctrl_d[p*CW + C_DOWN] = 1'b0;
        end
      end
      for (int b = 0; b < NUM_BUTTONS; b++)
        ctrl_d[p*CW + C_BTN0 + b] = raw[p*CW + C_BTN0 + b] &
                                    (phase_q | ~autofire_en[p*NUM_BUTTONS + b]);
      ctrl_d[p*CW + c_start(NUM_BUTTONS)] = raw[p*CW + c_start(NUM_BUTTONS)];
      ctrl_d[p*CW + c_coin(NUM_BUTTONS)]  = coin_busy[p];
      ctrl_d[p*CW + c_pause(NUM_BUTTONS)] = raw[p*CW + c_pause(NUM_BUTTONS)];
      coin_raw[p] = raw[p*CW + c_coin(NUM_BUTTONS)];
    end
  end

  for (genvar gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
    coin_stretch #(.COIN_PULSE(COIN_PULSE)) u_coin (
      .clk_sys   (clk_sys),
      .RESET     (RESET),
      .coin_raw  (coin_raw[gp]),
      .coin_busy (coin_busy[gp])
    );
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      key_q    <= '0;
      ctrl_q   <= '0;
      tog_q    <= 1'b0;
      prime_q  <= 1'b0;
      af_cnt_q <= '0;
      phase_q  <= 1'b1;
    end else begin
      key_q    <= key_d;
      ctrl_q   <= ctrl_d;
      tog_q    <= tog_d;
      prime_q  <= prime_d;
      af_cnt_q <= af_cnt_d;
      phase_q  <= phase_d;
    end
  end

  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Testbench for player_input_ctrl with default parameters
// (2 players, 4 buttons, COIN_PULSE 16, AUTOFIRE_HALF 4, SOCD on).
module tb_player_input_ctrl;

  localparam int NW = 22;

  logic          clk_sys = 1'b0;
  logic          RESET;
  logic [10:0]   ps2_key;
  logic [63:0]   joystick;
  logic [7:0]    autofire_en;
  logic [NW-1:0] ctrl_out;

  int checks = 0;
  int errors = 0;

  player_input_ctrl dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .ps2_key     (ps2_key),
    .joystick    (joystick),
    .autofire_en (autofire_en),
    .ctrl_out    (ctrl_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [63:0]   joy;
    logic [NW-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    int hi_cnt;
    int first_hi;

    vecs[0]  = '{64'h0,                    22'h0};
    vecs[1]  = '{64'h001,                  22'h001};
    vecs[2]  = '{64'h003,                  22'h000};
    vecs[3]  = '{64'h00C,                  22'h000};
    vecs[4]  = '{64'h00F,                  22'h000};
    vecs[5]  = '{64'h009,                  22'h009};
    vecs[6]  = '{64'h0F0,                  22'h0F0};
    vecs[7]  = '{64'h500,                  22'h500};
    vecs[8]  = '{{32'h006, 32'h0},         22'h003000};
    vecs[9]  = '{{32'h5FF, 32'h0},         22'h2F8000};
    vecs[10] = '{{32'h0, 32'hFFFF_F800},   22'h0};
    vecs[11] = '{64'h0,                    22'h0};

    // Reset with the toggle bit high and a mapped key on the bus.
    RESET       = 1'b1;
    joystick    = '0;
    autofire_en = '0;
    ps2_key     = {1'b1, 1'b1, 1'b1, 8'h75};
    tick(3);
    check("reset_state", 32'(ctrl_out), 32'h0);
    @(negedge clk_sys);
    RESET = 1'b0;
    tick(3);
    check("prime_no_event", 32'(ctrl_out), 32'h0);

    // Toggle -> event with E0-75 pressed: up after two edges.
    @(negedge clk_sys);
    ps2_key[10] = ~ps2_key[10];
    tick(1);
    check("up_lat1", 32'(ctrl_out), 32'h0);
    tick(1);
    check("up_lat2", 32'(ctrl_out), 32'h008);

    // Keypad 8 (no E0) is a different, unmapped key.
    send_key(1'b1, 1'b0, 8'h75);
    tick(2);
    check("kp8_no_change", 32'(ctrl_out), 32'h008);
    send_key(1'b0, 1'b1, 8'h75);
    tick(2);
    check("up_release", 32'(ctrl_out), 32'h0);

    // Key and joystick both hold right.
    @(negedge clk_sys);
    joystick[0] = 1'b1;
    tick(1);
    check("joy_right", 32'(ctrl_out), 32'h001);
    send_key(1'b1, 1'b1, 8'h74);
    tick(2);
    check("right_both", 32'(ctrl_out), 32'h001);
    @(negedge clk_sys);
    joystick[0] = 1'b0;
    tick(1);
    check("right_key_holds", 32'(ctrl_out), 32'h001);
    send_key(1'b0, 1'b1, 8'h74);
    tick(1);
    check("right_rel_lat1", 32'(ctrl_out), 32'h001);
    tick(1);
    check("right_rel_lat2", 32'(ctrl_out), 32'h0);

    // SOCD: key up + joystick down cancel.
    send_key(1'b1, 1'b1, 8'h75);
    tick(2);
    check("socd_up", 32'(ctrl_out), 32'h008);
    @(negedge clk_sys);
    joystick[2] = 1'b1;
    tick(1);
    check("socd_cancel", 32'(ctrl_out), 32'h0);
    @(negedge clk_sys);
    joystick[2] = 1'b0;
    tick(1);
    check("socd_restore", 32'(ctrl_out), 32'h008);
    send_key(1'b0, 1'b1, 8'h75);
    tick(2);
    check("socd_release", 32'(ctrl_out), 32'h0);

    // Unmapped Enter changes nothing; P2 'A' drives P2 button 1.
    send_key(1'b1, 1'b0, 8'h5A);
    tick(2);
    check("unmapped", 32'(ctrl_out), 32'h0);
    send_key(1'b1, 1'b0, 8'h1C);
    tick(2);
    check("p2_btn1", 32'(ctrl_out), 32'h008000);
    send_key(1'b0, 1'b0, 8'h1C);
    tick(2);
    check("p2_btn1_rel", 32'(ctrl_out), 32'h0);

    // Joystick table, autofire disabled.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      joystick = vecs[i].joy;
      tick(1);
      check($sformatf("vec%0d", i), 32'(ctrl_out), 32'(vecs[i].exp));
    end

    // Coin: one-cycle pulse, retrigger attempt at cycle 5.
    @(negedge clk_sys);
    joystick[9] = 1'b1;
    hi_cnt   = 0;
    first_hi = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_sys);
      #1;
      if (ctrl_out[9]) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = k;
      end
      @(negedge clk_sys);
      if (k == 1 || k == 5) joystick[9] = 1'b0;
      if (k == 4) joystick[9] = 1'b1;
    end
    check("coin_width", 32'(hi_cnt), 32'd16);
    check("coin_latency", 32'(first_hi), 32'd2);

    // Reset in the middle of a coin pulse.
    joystick[9] = 1'b1;
    @(negedge clk_sys);
    joystick[9] = 1'b0;
    tick(5);
    check("coin_active", 32'(ctrl_out), 32'h200);
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", 32'(ctrl_out), 32'h0);
    @(negedge clk_sys);
    RESET  = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      if (ctrl_out[9]) hi_cnt++;
    end
    check("coin_no_residual", 32'(hi_cnt), 32'd0);

    // Autofire on P1 button 1, held from reset.
    @(negedge clk_sys);
    RESET          = 1'b1;
    autofire_en[0] = 1'b1;
    joystick[4]    = 1'b1;
    @(negedge clk_sys);
    RESET = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      check($sformatf("autofire%0d", k), 32'(ctrl_out[4]), 32'(((k / 4) % 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
